// File: rtl/sawtooth_generator.sv
// 8-bit sawtooth generator for a Tiny Tapeout style wrapper: phase accumulator,
// shift-selected output window and a first-order PDM stream for an RC filter.
module sawtooth_generator #(
    parameter int ACC_W = 23
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int SH_W = $clog2(ACC_W);

    // Every shift setting (max 15) needs a full 8-bit window inside acc.
    if (ACC_W < 23) begin : g_acc_w_check
        $error("ACC_W must be at least 23");
    end

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [7:0]       pdm_acc_q, pdm_acc_d;
    logic             pdm_out_q, pdm_out_d;

    logic [3:0]       shift_by;
    logic             hold;
    logic             invert;
    logic [SH_W-1:0]  base;
    logic [7:0]       raw;
    logic [ACC_W-1:0] win_mask;
    logic             wrap_sync;
    logic [8:0]       pdm_sum;
    logic             unused_in;

    assign shift_by = ui_in[7:4];
    assign hold     = ui_in[1];
    assign invert   = ui_in[0];

    assign base   = SH_W'(shift_by);
    assign raw    = acc_q[base +: 8];
    assign uo_out = invert ? ~raw : raw;

    // Low shift_by+8 bits of acc all ones: last cycle before raw wraps to zero.
    assign win_mask  = ~({ACC_W{1'b1}} << (base + SH_W'(8)));
    assign wrap_sync = &(acc_q | ~win_mask);

    assign pdm_sum = {1'b0, pdm_acc_q} + {1'b0, uo_out};

    assign uio_out   = {pdm_out_q, wrap_sync, 6'b00_0000};
    assign uio_oe    = 8'b1100_0000;
    assign unused_in = ^{uio_in, ui_in[3:2]};

    always_comb begin
        acc_d     = acc_q;
        pdm_acc_d = pdm_acc_q;
        pdm_out_d = pdm_out_q;
        if (ena) begin
            if (!hold) begin
                acc_d = acc_q + ACC_W'(1);
            end
            // Modulator keeps running while held so a frozen sample keeps its density.
            pdm_acc_d = pdm_sum[7:0];
            pdm_out_d = pdm_sum[8];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q     <= '0;
            pdm_acc_q <= '0;
            pdm_out_q <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            pdm_acc_q <= pdm_acc_d;
            pdm_out_q <= pdm_out_d;
        end
    end

endmodule

// File: tb/tb_sawtooth_generator.sv
// Directed bench for sawtooth_generator: hand-computed spot values plus a small
// behavioural model of accumulator, sample window, wrap pulse and PDM stream.
module tb_sawtooth_generator;

    logic       clk;
    logic       rst;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int n_chk;
    int n_err;

    logic [22:0] m_acc;
    logic [7:0]  m_pacc;
    logic        m_pdm;

    sawtooth_generator #(.ACC_W(23)) dut (
        .clk     (clk),
        .rst     (rst),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] m_uo(input logic [22:0] a, input logic [7:0] ui);
        logic [22:0] s;
        s = a >> ui[7:4];
        return ui[0] ? ~s[7:0] : s[7:0];
    endfunction

    function automatic logic m_wrap(input logic [22:0] a, input logic [7:0] ui);
        logic [31:0] lm;
        lm = (32'd1 << (int'(ui[7:4]) + 8)) - 32'd1;
        return ({9'd0, a} & lm) == lm;
    endfunction

    task automatic step();
        logic [8:0] s;
        s = {1'b0, m_pacc} + {1'b0, m_uo(m_acc, ui_in)};
        @(posedge clk);
        if (rst) begin
            m_acc  = '0;
            m_pacc = '0;
            m_pdm  = 1'b0;
        end else if (ena) begin
            if (!ui_in[1]) m_acc = m_acc + 23'd1;
            m_pacc = s[7:0];
            m_pdm  = s[8];
        end
        @(negedge clk);
    endtask

    task automatic check_outs();
        check("uo", {24'd0, uo_out}, {24'd0, m_uo(m_acc, ui_in)});
        check("wrap", {31'd0, uio_out[6]}, {31'd0, m_wrap(m_acc, ui_in)});
        check("pdm", {31'd0, uio_out[7]}, {31'd0, m_pdm});
        check("uio_lo", {26'd0, uio_out[5:0]}, 32'd0);
        check("oe", {24'd0, uio_oe}, 32'h0000_00C0);
    endtask

    task automatic do_reset(input logic [7:0] ui);
        ui_in = ui;
        rst   = 1'b1;
        step();
        rst   = 1'b0;
    endtask

    initial begin
        int ones;
        int win;
        n_chk  = 0;
        n_err  = 0;
        m_acc  = '0;
        m_pacc = '0;
        m_pdm  = 1'b0;
        rst    = 1'b1;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;

        // Reset and basic ramp at shift 0
        do_reset(8'h00);
        check("rst_uo", {24'd0, uo_out}, 32'h00);
        check("rst_uio", {24'd0, uio_out}, 32'h00);
        check_outs();
        for (int k = 1; k <= 256; k++) begin
            step();
            check_outs();
            if (k == 1)   check("ramp_01", {24'd0, uo_out}, 32'h01);
            if (k == 254) check("ramp_nowrap", {31'd0, uio_out[6]}, 32'd0);
            if (k == 255) begin
                check("ramp_ff", {24'd0, uo_out}, 32'hFF);
                check("ramp_wrap", {31'd0, uio_out[6]}, 32'd1);
            end
            if (k == 256) begin
                check("ramp_00", {24'd0, uo_out}, 32'h00);
                check("ramp_wrap_end", {31'd0, uio_out[6]}, 32'd0);
            end
        end

        // shift_by = 3
        do_reset(8'h30);
        for (int k = 1; k <= 2048; k++) begin
            step();
            check_outs();
            if (k == 7)    check("sh3_k7", {24'd0, uo_out}, 32'h00);
            if (k == 8)    check("sh3_k8", {24'd0, uo_out}, 32'h01);
            if (k == 2047) begin
                check("sh3_ff", {24'd0, uo_out}, 32'hFF);
                check("sh3_wrap", {31'd0, uio_out[6]}, 32'd1);
            end
            if (k == 2048) check("sh3_00", {24'd0, uo_out}, 32'h00);
        end

        // Inverted ramp
        do_reset(8'h01);
        check("inv_rst", {24'd0, uo_out}, 32'hFF);
        for (int k = 1; k <= 256; k++) begin
            step();
            check_outs();
            if (k == 1)   check("inv_fe", {24'd0, uo_out}, 32'hFE);
            if (k == 255) begin
                check("inv_00", {24'd0, uo_out}, 32'h00);
                check("inv_wrap", {31'd0, uio_out[6]}, 32'd1);
            end
            if (k == 256) check("inv_back_ff", {24'd0, uo_out}, 32'hFF);
        end

        // Hold at 0x40: PDM density 1 of 4
        do_reset(8'h00);
        for (int k = 0; k < 64; k++) step();
        check("pre_hold", {24'd0, uo_out}, 32'h40);
        ui_in = 8'h02;
        ones  = 0;
        win   = 0;
        for (int k = 0; k < 256; k++) begin
            step();
            check_outs();
            check("hold_uo", {24'd0, uo_out}, 32'h40);
            ones += int'(uio_out[7]);
            win  += int'(uio_out[7]);
            if ((k % 4) == 3) begin
                check("hold_win4", win, 32'd1);
                win = 0;
            end
        end
        check("hold_density", ones, 32'd64);

        // ena low freezes everything
        ui_in = 8'h00;
        for (int k = 0; k < 10; k++) step();
        check("pre_ena", {24'd0, uo_out}, 32'h4A);
        ena = 1'b0;
        for (int k = 0; k < 100; k++) begin
            step();
            check_outs();
            check("ena0_uo", {24'd0, uo_out}, 32'h4A);
        end
        ena = 1'b1;
        step();
        check_outs();
        check("ena_resume", {24'd0, uo_out}, 32'h4B);

        // Mid-ramp reset at shift 5, then junk on unused inputs
        ui_in = 8'h50;
        for (int k = 0; k < 300; k++) begin
            step();
            check_outs();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_uo", {24'd0, uo_out}, 32'h00);
        check("midrst_pdm", {31'd0, uio_out[7]}, 32'd0);
        for (int k = 0; k < 200; k++) begin
            uio_in      = 8'($urandom);
            ui_in[3:2]  = 2'($urandom_range(0, 3));
            step();
            check_outs();
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
